// File: rtl/seg_display_arbiter.sv
// Round-robin arbiter sharing one 7-segment display and LED between two requesters.
// Grant visible one cycle after request; pattern held HOLD_CYCLES cycles; requests are never buffered.
module seg_display_arbiter #(
    parameter int         HOLD_CYCLES  = 50_000_000,
    parameter int         BLINK_CYCLES = 12_500_000,
    parameter logic [6:0] IDLE_PATTERN = 7'h7F
) (
    input  logic       clk_clk,
    input  logic       reset_reset,
    input  logic [1:0] req_valid,
    input  logic [6:0] req_pattern0,
    input  logic [6:0] req_pattern1,
    output logic [1:0] req_ready,
    output logic [1:0] req_done,
    input  logic [3:0] switches_in,
    output logic [6:0] seg_out,
    output logic       led_out,
    output logic       busy,
    output logic       owner
);

    localparam int CW = $clog2(HOLD_CYCLES + 1);
    localparam int BW = $clog2(BLINK_CYCLES + 1);
    localparam logic [CW-1:0] HOLD_LOAD  = CW'(HOLD_CYCLES - 1);
    localparam logic [BW-1:0] BLINK_LOAD = BW'(BLINK_CYCLES - 1);

    typedef enum logic {
        IDLE,
        HOLD
    } state_t;

    state_t        state;
    logic [CW-1:0] hold_cnt;
    logic [BW-1:0] blink_cnt;
    logic [1:0]    sw_meta;
    logic [1:0]    sw_sync;
    logic          freeze;
    logic          pause;
    logic          winner;
    logic          unused_sw;

    assign freeze    = sw_sync[0];
    assign pause     = sw_sync[1];
    assign unused_sw = ^switches_in[3:2];

    // On a tie the requester that did not hold the display last time wins.
    assign winner = (req_valid == 2'b11) ? ~owner : req_valid[1];

    // Done is decoded from registered state so a pause landing on the last
    // dwell cycle suppresses it until the pause is released.
    assign req_done = (state == HOLD && hold_cnt == '0 && !pause)
                    ? (owner ? 2'b10 : 2'b01) : 2'b00;

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            state     <= IDLE;
            hold_cnt  <= '0;
            blink_cnt <= '0;
            sw_meta   <= '0;
            sw_sync   <= '0;
            seg_out   <= IDLE_PATTERN;
            led_out   <= 1'b0;
            busy      <= 1'b0;
            owner     <= 1'b1;
            req_ready <= 2'b00;
        end else begin
            sw_meta   <= switches_in[1:0];
            sw_sync   <= sw_meta;
            req_ready <= 2'b00;
            case (state)
                IDLE: begin
                    seg_out   <= IDLE_PATTERN;
                    led_out   <= 1'b0;
                    blink_cnt <= '0;
                    busy      <= 1'b0;
                    if (req_valid != 2'b00 && !freeze) begin
                        state     <= HOLD;
                        owner     <= winner;
                        seg_out   <= winner ? req_pattern1 : req_pattern0;
                        req_ready <= winner ? 2'b10 : 2'b01;
                        hold_cnt  <= HOLD_LOAD;
                        blink_cnt <= BLINK_LOAD;
                        led_out   <= 1'b1;
                        busy      <= 1'b1;
                    end
                end
                HOLD: begin
                    // The LED keeps blinking through a pause; only the dwell stops.
                    if (blink_cnt == '0) begin
                        led_out   <= ~led_out;
                        blink_cnt <= BLINK_LOAD;
                    end else begin
                        blink_cnt <= blink_cnt - 1'b1;
                    end
                    if (!pause) begin
                        if (hold_cnt == '0) begin
                            state     <= IDLE;
                            seg_out   <= IDLE_PATTERN;
                            busy      <= 1'b0;
                            led_out   <= 1'b0;
                            blink_cnt <= '0;
                        end else begin
                            hold_cnt <= hold_cnt - 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
